// File: rtl/coregpio_deb_pkg.sv
// Shared register map and reset constants for the debounced APB GPIO block.
// Offsets are byte addresses; the low two address bits are never decoded.
package coregpio_deb_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [7:0] OFF_DATA_IN    = 8'h00;
  localparam logic [7:0] OFF_DATA_OUT   = 8'h04;
  localparam logic [7:0] OFF_OE         = 8'h08;
  localparam logic [7:0] OFF_INT_EN     = 8'h0C;
  localparam logic [7:0] OFF_INT_POS    = 8'h10;
  localparam logic [7:0] OFF_INT_NEG    = 8'h14;
  localparam logic [7:0] OFF_INT_STAT   = 8'h18;
  localparam logic [7:0] OFF_DEB_PERIOD = 8'h1C;

  localparam logic [31:0] RST_VAL = 32'h0000_0000;

endpackage

// File: rtl/coregpio_deb_chan.sv
// One GPIO input channel: 2-flop synchroniser then a debounce filter; latency 2 + period + 1 cycles.
// rise/fall pulse for one cycle, combinationally, on the edge where the filtered value flips.
module coregpio_deb_chan
  import coregpio_deb_pkg::*;
#(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin_in,
  input  logic [DEB_W-1:0] deb_period,
  output logic             stable,
  output logic             rise,
  output logic             fall
);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             qualify;

  // The >= compare lets a lowered period take effect on the very next cycle.
  always_comb begin
    meta_d   = pin_in;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    qualify  = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= deb_period) begin
      qualify  = 1'b1;
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= RST_VAL[0];
      sync_q   <= RST_VAL[0];
      stable_q <= RST_VAL[0];
      cnt_q    <= DEB_W'(RST_VAL);
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = qualify & sync_q;
  assign fall   = qualify & ~sync_q;

endmodule

// File: rtl/coregpio_deb_apb.sv
// APB3 GPIO with per-channel debounce and sticky edge interrupts; zero wait states, PREADY tied high.
// Register writes land on the access-phase edge; PRDATA, PSLVERR and INT are combinational from state.
module coregpio_deb_apb
  import coregpio_deb_pkg::*;
#(
  parameter int IO_NUM = 8,
  parameter int DEB_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  logic [IO_NUM-1:0] data_out_q, data_out_d;
  logic [IO_NUM-1:0] oe_q, oe_d;
  logic [IO_NUM-1:0] int_en_q, int_en_d;
  logic [IO_NUM-1:0] int_pos_q, int_pos_d;
  logic [IO_NUM-1:0] int_neg_q, int_neg_d;
  logic [IO_NUM-1:0] int_stat_q, int_stat_d;
  logic [DEB_W-1:0]  deb_period_q, deb_period_d;

  logic [IO_NUM-1:0] stable_vec, rise_vec, fall_vec, w1c_mask;
  logic [7:0]        reg_off;
  logic              wr_en, mapped, unused_bits;

  assign reg_off     = {PADDR[7:2], 2'b00};
  assign mapped      = PADDR[7:2] < 6'(NUM_REGS);
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  for (genvar i = 0; i < IO_NUM; i++) begin : g_chan
    coregpio_deb_chan #(.DEB_W(DEB_W)) u_chan (
      .clk       (PCLK),
      .rst       (PRESET),
      .pin_in    (GPIO_IN[i]),
      .deb_period(deb_period_q),
      .stable    (stable_vec[i]),
      .rise      (rise_vec[i]),
      .fall      (fall_vec[i])
    );
  end

  always_comb begin
    data_out_d   = data_out_q;
    oe_d         = oe_q;
    int_en_d     = int_en_q;
    int_pos_d    = int_pos_q;
    int_neg_d    = int_neg_q;
    deb_period_d = deb_period_q;
    w1c_mask     = '0;
    if (wr_en) begin
      case (reg_off)
        OFF_DATA_OUT:   data_out_d   = PWDATA[IO_NUM-1:0];
        OFF_OE:         oe_d         = PWDATA[IO_NUM-1:0];
        OFF_INT_EN:     int_en_d     = PWDATA[IO_NUM-1:0];
        OFF_INT_POS:    int_pos_d    = PWDATA[IO_NUM-1:0];
        OFF_INT_NEG:    int_neg_d    = PWDATA[IO_NUM-1:0];
        OFF_INT_STAT:   w1c_mask     = PWDATA[IO_NUM-1:0];
        OFF_DEB_PERIOD: deb_period_d = PWDATA[DEB_W-1:0];
        default:        ;
      endcase
    end
    // New events are ORed in after the clear so a coincident event survives.
    int_stat_d = (int_stat_q & ~w1c_mask) | (rise_vec & int_pos_q) | (fall_vec & int_neg_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out_q   <= IO_NUM'(RST_VAL);
      oe_q         <= IO_NUM'(RST_VAL);
      int_en_q     <= IO_NUM'(RST_VAL);
      int_pos_q    <= IO_NUM'(RST_VAL);
      int_neg_q    <= IO_NUM'(RST_VAL);
      int_stat_q   <= IO_NUM'(RST_VAL);
      deb_period_q <= DEB_W'(RST_VAL);
    end else begin
      data_out_q   <= data_out_d;
      oe_q         <= oe_d;
      int_en_q     <= int_en_d;
      int_pos_q    <= int_pos_d;
      int_neg_q    <= int_neg_d;
      int_stat_q   <= int_stat_d;
      deb_period_q <= deb_period_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (reg_off)
        OFF_DATA_IN:    PRDATA = 32'(stable_vec);
        OFF_DATA_OUT:   PRDATA = 32'(data_out_q);
        OFF_OE:         PRDATA = 32'(oe_q);
        OFF_INT_EN:     PRDATA = 32'(int_en_q);
        OFF_INT_POS:    PRDATA = 32'(int_pos_q);
        OFF_INT_NEG:    PRDATA = 32'(int_neg_q);
        OFF_INT_STAT:   PRDATA = 32'(int_stat_q);
        OFF_DEB_PERIOD: PRDATA = 32'(deb_period_q);
        default:        PRDATA = '0;
      endcase
    end
  end

  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & ~mapped;
  assign GPIO_OUT = data_out_q;
  assign GPIO_OE  = oe_q;
  assign INT      = int_stat_q & int_en_q;
  assign INT_OR   = |INT;

endmodule
